// File: rtl/rfphoenix_reb_tracker_pkg.sv
// Shared types and constants for the reorder-entry tracker.
package rfphoenix_reb_tracker_pkg;

  localparam int REB_ENTRIES = 12;
  localparam int NTHREADS    = 16;
  localparam int CAUSE_W     = 12;

  typedef enum logic [1:0] {
    ST_FREE     = 2'd0,
    ST_DECODED  = 2'd1,
    ST_OUT      = 2'd2,
    ST_EXECUTED = 2'd3
  } RebState;

  typedef logic [$clog2(NTHREADS)-1:0] Tid;
  typedef logic [CAUSE_W-1:0]          CauseCode;

endpackage

// File: rtl/rfphoenix_reb_tracker_if.sv
// Allocation / issue / done / flush / commit bundle of the tracker.
interface rfphoenix_reb_tracker_if #(
  parameter int NENTRIES = rfphoenix_reb_tracker_pkg::REB_ENTRIES,
  parameter int NTHREADS = rfphoenix_reb_tracker_pkg::NTHREADS,
  parameter int TW       = $clog2(NTHREADS),
  parameter int IW       = $clog2(NENTRIES)
);
  import rfphoenix_reb_tracker_pkg::*;

  localparam int CW = $clog2(NENTRIES+1);

  logic          alloc_req;
  logic [TW-1:0] alloc_tid;
  logic          alloc_rdy;
  logic [IW-1:0] alloc_idx;
  logic          issue_v;
  logic [IW-1:0] issue_idx;
  logic          done_v;
  logic [IW-1:0] done_idx;
  CauseCode      done_cause;
  logic          flush_v;
  logic [TW-1:0] flush_tid;
  logic          cmt_v;
  logic [IW-1:0] cmt_idx;
  logic [TW-1:0] cmt_tid;
  CauseCode      cmt_cause;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport master (
    output alloc_req, alloc_tid, issue_v, issue_idx, done_v, done_idx,
           done_cause, flush_v, flush_tid,
    input  alloc_rdy, alloc_idx, cmt_v, cmt_idx, cmt_tid, cmt_cause,
           count, full, empty
  );

  modport slave (
    input  alloc_req, alloc_tid, issue_v, issue_idx, done_v, done_idx,
           done_cause, flush_v, flush_tid,
    output alloc_rdy, alloc_idx, cmt_v, cmt_idx, cmt_tid, cmt_cause,
           count, full, empty
  );

endinterface

// File: rtl/rfphoenix_ffo.sv
// Find-first-one: index of the lowest set bit, plus an any-set flag.
module rfphoenix_ffo #(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic          found,
  output logic [IW-1:0] idx
);

  // scan from the top so the lowest set bit is the last write
  always_comb begin
    found = |vec;
    idx   = '0;
    for (int i = W-1; i >= 0; i--)
      if (vec[i]) idx = IW'(i);
  end

endmodule

// File: rtl/rfphoenix_reb_tracker.sv
// Reorder-entry tracker: per-thread in-order commit, cross-thread
// out-of-order commit, age kept as an older-than matrix.
module rfphoenix_reb_tracker #(
  parameter int NENTRIES = rfphoenix_reb_tracker_pkg::REB_ENTRIES,
  parameter int NTHREADS = rfphoenix_reb_tracker_pkg::NTHREADS,
  parameter int TW       = $clog2(NTHREADS),
  parameter int IW       = $clog2(NENTRIES)
) (
  input logic clk,
  input logic rst,
  rfphoenix_reb_tracker_if.slave bus
);
  import rfphoenix_reb_tracker_pkg::*;

  localparam int CW = $clog2(NENTRIES+1);

  RebState       st_q    [NENTRIES];
  logic [TW-1:0] tid_q   [NENTRIES];
  CauseCode      cause_q [NENTRIES];
  // older_q[i][j] = 1: entry j was allocated before entry i
  logic [NENTRIES-1:0][NENTRIES-1:0] older_q;
  logic [CW-1:0] count_q;

  logic [NENTRIES-1:0] free_vec, busy_vec, flush_vec, cand_vec, oldest_vec;
  logic                alloc_rdy, alloc_fire, cmt_found, cmt_fire;
  logic [IW-1:0]       alloc_idx, cmt_idx;
  logic [TW-1:0]       cmt_tid;
  CauseCode            cmt_cause;
  logic [CW-1:0]       nflush;

  // occupancy and flush-target vectors
  always_comb begin
    free_vec  = '0;
    busy_vec  = '0;
    flush_vec = '0;
    for (int i = 0; i < NENTRIES; i++) begin
      free_vec[i]  = (st_q[i] == ST_FREE);
      busy_vec[i]  = (st_q[i] != ST_FREE);
      flush_vec[i] = bus.flush_v && (st_q[i] != ST_FREE) && (tid_q[i] == bus.flush_tid);
    end
  end

  // commit candidates: executed with no older live entry of the same thread
  always_comb begin
    cand_vec = '0;
    for (int i = 0; i < NENTRIES; i++) begin
      cand_vec[i] = (st_q[i] == ST_EXECUTED);
      for (int j = 0; j < NENTRIES; j++)
        if (older_q[i][j] && busy_vec[j] && (tid_q[j] == tid_q[i]))
          cand_vec[i] = 1'b0;
    end
  end

  // oldest candidate overall; age is a total order so this is one-hot
  always_comb begin
    oldest_vec = '0;
    for (int i = 0; i < NENTRIES; i++) begin
      oldest_vec[i] = cand_vec[i];
      for (int j = 0; j < NENTRIES; j++)
        if (older_q[i][j] && cand_vec[j]) oldest_vec[i] = 1'b0;
    end
  end

  rfphoenix_ffo #(.W(NENTRIES), .IW(IW)) u_free_ffo (
    .vec   (free_vec),
    .found (alloc_rdy),
    .idx   (alloc_idx)
  );

  rfphoenix_ffo #(.W(NENTRIES), .IW(IW)) u_cmt_ffo (
    .vec   (oldest_vec),
    .found (cmt_found),
    .idx   (cmt_idx)
  );

  // commit payload mux
  always_comb begin
    cmt_tid   = '0;
    cmt_cause = '0;
    for (int i = 0; i < NENTRIES; i++)
      if (oldest_vec[i]) begin
        cmt_tid   = tid_q[i];
        cmt_cause = cause_q[i];
      end
  end

  // a candidate being flushed must not also be reported as committed
  assign alloc_fire = bus.alloc_req && alloc_rdy;
  assign cmt_fire   = cmt_found && !(bus.flush_v && (cmt_tid == bus.flush_tid));

  // number of entries killed by this cycle's flush
  always_comb begin
    nflush = '0;
    for (int i = 0; i < NENTRIES; i++) nflush = nflush + CW'(flush_vec[i]);
  end

  // per-entry state: flush/commit free, alloc fills a free slot, then issue/done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NENTRIES; i++) begin
        st_q[i]    <= ST_FREE;
        tid_q[i]   <= '0;
        cause_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NENTRIES; i++) begin
        if (flush_vec[i] || (cmt_fire && (cmt_idx == IW'(i)))) begin
          st_q[i] <= ST_FREE;
        end else if (alloc_fire && (alloc_idx == IW'(i))) begin
          st_q[i]    <= ST_DECODED;
          tid_q[i]   <= bus.alloc_tid;
          cause_q[i] <= '0;
        end else if (bus.issue_v && (bus.issue_idx == IW'(i)) && (st_q[i] == ST_DECODED)) begin
          st_q[i] <= ST_OUT;
        end else if (bus.done_v && (bus.done_idx == IW'(i)) && (st_q[i] == ST_OUT)) begin
          st_q[i]    <= ST_EXECUTED;
          cause_q[i] <= bus.done_cause;
        end
      end
    end
  end

  // new entry is younger than every live entry; clear its stale column
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      older_q <= '0;
    end else if (alloc_fire) begin
      for (int i = 0; i < NENTRIES; i++)
        for (int j = 0; j < NENTRIES; j++)
          if (alloc_idx == IW'(i))      older_q[i][j] <= busy_vec[j];
          else if (alloc_idx == IW'(j)) older_q[i][j] <= 1'b0;
    end
  end

  // occupancy counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_q + CW'(alloc_fire) - CW'(cmt_fire) - nflush;
  end

  assign bus.alloc_rdy = alloc_rdy;
  assign bus.alloc_idx = alloc_idx;
  assign bus.cmt_v     = cmt_fire;
  assign bus.cmt_idx   = cmt_idx;
  assign bus.cmt_tid   = cmt_tid;
  assign bus.cmt_cause = cmt_cause;
  assign bus.count     = count_q;
  assign bus.full      = (count_q == CW'(NENTRIES));
  assign bus.empty     = (count_q == '0);

endmodule
